// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one transaction at a time onto a single-port synchronous SRAM.
// Supports FIXED/INCR/WRAP bursts up to 16 beats with 4-byte beats.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic                sram_ceb,
    output logic                sram_web,
    output logic [DATA_W-1:0]   sram_bweb,
    output logic [SRAM_AW-1:0]  sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [4:0]          beat_q, beat_d;
    logic [1:0]          bresp_q, bresp_d;

    logic [SRAM_AW-1:0]  nxt_addr;
    logic [4:0]          beat_inc;
    logic                beat_last;

    // Size and out-of-window address bits are decoded upstream.
    logic unused_ok;
    assign unused_ok = ^{AWSIZE, ARSIZE, AWADDR[1:0], ARADDR[1:0],
                         AWADDR[ADDR_W-1:SRAM_AW+2], ARADDR[ADDR_W-1:SRAM_AW+2]};

    function automatic logic [SRAM_AW-1:0] next_addr(input logic [SRAM_AW-1:0] a,
                                                     input logic [3:0] len,
                                                     input logic [1:0] bu);
        logic [SRAM_AW-1:0] inc, mask, res;
        inc  = a + {{(SRAM_AW-1){1'b0}}, 1'b1};
        mask = {{(SRAM_AW-4){1'b0}}, len};
        res  = inc;
        if (bu == 2'b00)
            res = a;
        else if (bu == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            res = (a & ~mask) | (inc & mask);
        return res;
    endfunction

    assign nxt_addr  = next_addr(addr_q, len_q, burst_q);
    // Saturate so overlong write bursts never alias back onto len.
    assign beat_inc  = beat_q[4] ? beat_q : beat_q + 5'd1;
    assign beat_last = (beat_q == {1'b0, len_q});

    assign BID   = id_q;
    assign RID   = id_q;
    assign BRESP = bresp_q;
    assign RRESP = 2'b00;
    assign RDATA = sram_do;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        bresp_d   = bresp_q;
        AWREADY   = 1'b0;
        ARREADY   = 1'b0;
        WREADY    = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        BVALID    = 1'b0;
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = addr_q;
        sram_di   = WDATA;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    AWREADY = 1'b1;
                    ARREADY = ~AWVALID;
                    if (AWVALID) begin
                        id_d    = AWID;
                        addr_d  = AWADDR[SRAM_AW+1:2];
                        len_d   = AWLEN;
                        burst_d = AWBURST;
                        beat_d  = '0;
                        state_d = WRITE;
                    end else if (ARVALID) begin
                        id_d     = ARID;
                        addr_d   = ARADDR[SRAM_AW+1:2];
                        len_d    = ARLEN;
                        burst_d  = ARBURST;
                        beat_d   = '0;
                        sram_ceb = 1'b0;
                        sram_a   = ARADDR[SRAM_AW+1:2];
                        state_d  = READ;
                    end
                end
                READ: begin
                    RVALID   = 1'b1;
                    RLAST    = beat_last;
                    sram_ceb = 1'b0;
                    // Re-reading the current word while stalled keeps sram_do stable.
                    if (RREADY) begin
                        if (beat_last) begin
                            sram_ceb = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            sram_a = nxt_addr;
                            addr_d = nxt_addr;
                            beat_d = beat_inc;
                        end
                    end
                end
                WRITE: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        sram_ceb = 1'b0;
                        sram_web = 1'b0;
                        for (int i = 0; i < DATA_W/8; i++)
                            sram_bweb[8*i +: 8] = {8{~WSTRB[i]}};
                        addr_d = nxt_addr;
                        beat_d = beat_inc;
                        if (WLAST) begin
                            bresp_d = beat_last ? 2'b00 : 2'b10;
                            state_d = RESP;
                        end
                    end
                end
                RESP: begin
                    BVALID = 1'b1;
                    if (BREADY) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave that terminates transactions from the CPU-side AXI master and maps them onto one synchronous single-port SRAM macro (instruction or data memory).
- Sits directly downstream of the master, behind the bus interconnect.
- Serves the master's traffic:
  - 4-beat INCR line-fill reads on 16-byte-aligned addresses.
  - Single-beat FIXED byte/half/word writes with WSTRB.
- Also handles general FIXED/INCR/WRAP bursts up to 16 beats.

Parameters:
ID_W, 8, AXI ID width on the slave side (master ID plus interconnect-added bits)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; fixed 4-byte beats
SRAM_AW, 14, SRAM word-address width (depth 2^SRAM_AW words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/4/3/2  write address channel payload
AWVALID in 1, AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data payload
WVALID in 1, WREADY out 1  write data handshake
BID/BRESP  out  ID_W/2  write response payload
BVALID out 1, BREADY in 1  write response handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/4/3/2  read address channel payload
ARVALID in 1, ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data payload
RVALID out 1, RREADY in 1  read data handshake
sram_ceb/sram_web  out  1/1  SRAM chip enable / write enable, active low
sram_bweb  out  DATA_W  per-bit write mask, active low
sram_a  out  SRAM_AW  SRAM word address
sram_di out DATA_W; sram_do in DATA_W  SRAM write data / read data (do valid 1 cycle after read access)

Behaviour:
- Reset and outputs:
  - rst asserted (any time, including mid-burst): state=IDLE, counters cleared.
  - RVALID=BVALID=RLAST=0; AWREADY=ARREADY=WREADY=0 while rst=1.
  - sram_ceb=sram_web=1; sram_bweb all 1.
- States:
  - IDLE:
    - AWREADY=1.
    - ARREADY=~AWVALID, so a write wins when AWVALID and ARVALID are both high.
    - AW handshake: latch AWID, word addr=AWADDR[SRAM_AW+1:2], len=AWLEN, burst=AWBURST, beat=0; go WRITE.
    - AR handshake: latch ARID/addr/len/burst, beat=0; issue SRAM read of ARADDR word in the same cycle (sram_ceb=0, web=1); go READ.
  - READ:
    - RVALID=1, RDATA=sram_do, RID=latched ID, RRESP=2'b00, RLAST=(beat==len).
    - First RVALID appears the cycle after the AR handshake.
    - Each cycle sram_ceb=0, web=1.
    - sram_a=next address if RVALID&RREADY, else current address. sram_do therefore stays stable under backpressure.
    - Handshake with RLAST: go IDLE with no SRAM access that cycle; otherwise beat++.
  - WRITE:
    - WREADY=1.
    - On each W handshake: sram_ceb=0, web=0, sram_a=current addr, sram_di=WDATA; byte i of sram_bweb=~{8{WSTRB[i]}}. Then advance addr, beat++.
    - WVALID asserted in the AW handshake cycle is not accepted; it is taken the next cycle (master holds WVALID).
    - Burst ends on a W handshake with WLAST=1. Go RESP; BRESP=2'b00 if beat==len at that beat, else 2'b10 (SLVERR).
    - Beats beyond len are still written at advancing addresses.
  - RESP:
    - BVALID=1, BID=latched AWID; hold until BREADY.
    - On B handshake go IDLE; the next AW/AR can be accepted the following cycle.
- Address update per beat, on the word index:
  - FIXED (00): unchanged.
  - INCR (01) and reserved 11: +1, wrapping modulo 2^SRAM_AW.
  - WRAP (10) with len in {1,3,7,15}: low log2(len+1) bits increment and wrap; upper bits fixed. WRAP with any other len is treated as INCR.
- AxSIZE is ignored (always 4-byte beats). AxADDR[1:0] and bits above SRAM_AW+1 are ignored (the interconnect decodes them).
- Only one outstanding transaction; no read/write overlap.

Test Plan:
- Line-fill read:
  - Stimulus: preload mem[16..19]=0xA0..0xA3; AR ARADDR=0x40, ARLEN=3, INCR, ARID=0x05, RREADY=1.
  - Response: RVALID the cycle after the AR handshake; RDATA 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; RLAST only on the 4th beat; RID=0x05; ARREADY=1 again the cycle after.
- Backpressure:
  - Stimulus: same read, RREADY=0 for 3 cycles after beat 1.
  - Response: RDATA held at 0xA1 with RVALID=1 throughout; sequence completes unchanged.
- Byte-masked write:
  - Stimulus: mem[4]=0x11223344; write AWADDR=0x10, AWLEN=0, FIXED, WSTRB=0011, WDATA=0xAABBCCDD, WLAST=1; WVALID asserted in the AW handshake cycle.
  - Response: W accepted the next cycle; mem[4]=0x1122CCDD; BVALID with BRESP=00 and BID echoed.
- Collision:
  - Stimulus: AWVALID and ARVALID high together.
  - Response: AW accepted first, ARREADY=0 until the B handshake completes; the read is accepted the cycle after.
- WRAP read and early WLAST:
  - Stimulus: WRAP read with ARLEN=3 at 0x18.
  - Response: words 6,7,4,5 returned.
  - Stimulus: write with AWLEN=3 and WLAST on beat 2.
  - Response: BRESP=10.
- Reset mid-burst:
  - Stimulus: assert rst during beat 2 of a read.
  - Response: RVALID drops immediately; sram_ceb=1; after release, a fresh AR is accepted normally.
